// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt request/service core.
// Contents: INTA phase encodings, the 3-bit level index type, the spurious
// index, and a helper that ranks a level against the rotation pointer.
package pic_pkg;

    localparam logic [1:0] INTA_IDLE   = 2'b00;
    localparam logic [1:0] INTA_FIRST  = 2'b01;
    localparam logic [1:0] INTA_SECOND = 2'b10;

    typedef logic [2:0] level_idx_t;

    localparam level_idx_t SPURIOUS_IDX = 3'd7;

    // Rank 0 is the highest priority (lowest+1), rank 7 is `lowest` itself.
    function automatic level_idx_t prio_rank(input level_idx_t idx, input level_idx_t lowest);
        return idx - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/interrupt_block_if.sv
// Bus between the PIC control logic and the interrupt request/service core.
// master: control side (drives IR lines, mask, mode bits, EOI and INTA phase).
// slave:  interrupt_block (returns INTtocontrol and ISRtocontrol).
interface interrupt_block_if;
    logic       i0, i1, i2, i3, i4, i5, i6, i7;
    logic       level_or_edge_flag;
    logic [7:0] mask;
    logic       set;
    logic       reset;
    logic       aeoi;
    logic       eoi;
    logic [1:0] intAcounter;
    logic       INTtocontrol;
    logic [2:0] ISRtocontrol;

    modport master (
        output i0, i1, i2, i3, i4, i5, i6, i7,
        output level_or_edge_flag, mask, set, reset, aeoi, eoi, intAcounter,
        input  INTtocontrol, ISRtocontrol
    );

    modport slave (
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        input  level_or_edge_flag, mask, set, reset, aeoi, eoi, intAcounter,
        output INTtocontrol, ISRtocontrol
    );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating priority encoder.
// Ports: i_req    - 8-bit request vector
//        i_lowest - index of the lowest-priority level (lowest+1 is highest)
//        o_valid  - any request bit set
//        o_idx    - index of the highest-priority set bit
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] i_req,
    input  level_idx_t i_lowest,
    output logic       o_valid,
    output level_idx_t o_idx
);

    level_idx_t w_pos;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = 7; k >= 0; k--) begin
            w_pos = i_lowest + 3'd1 + k[2:0];
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/interrupt_block.sv
// Interrupt request/service core of an 8259-style PIC: IRR capture (level or
// rising edge), masking, fully nested priority with optional rotation, INTA
// acknowledge into the ISR, automatic and non-specific EOI.
// Ports: clk   - system clock
//        rst_n - synchronous active-low block reset
//        bus   - interrupt_block_if.slave (IR lines, mode bits, EOI, INTA
//                phase in; INTtocontrol, ISRtocontrol out)
module interrupt_block
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    interrupt_block_if.slave   bus
);

    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [7:0] r_in_prev;
    logic [1:0] r_inta_prev;
    level_idx_t r_lowest;
    level_idx_t r_ack_idx;
    logic       r_spurious;

    logic [7:0] w_in;
    logic [7:0] w_req;
    logic       w_cand_valid;
    level_idx_t w_cand_idx;
    logic       w_first_evt;
    logic       w_second_evt;
    logic       w_aeoi_clr;
    logic [7:0] w_isr_eoi_view;
    logic       w_isr_valid;
    level_idx_t w_isr_idx;
    logic       w_blocked;
    logic [7:0] w_irr_next;
    logic [7:0] w_isr_next;
    level_idx_t w_lowest_next;

    assign w_in  = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};
    assign w_req = r_irr & ~bus.mask;

    pic_priority_resolver u_req_res (
        .i_req    (w_req),
        .i_lowest (r_lowest),
        .o_valid  (w_cand_valid),
        .o_idx    (w_cand_idx)
    );

    assign w_first_evt  = (bus.intAcounter != r_inta_prev) && (bus.intAcounter == INTA_FIRST);
    assign w_second_evt = (bus.intAcounter != r_inta_prev) && (bus.intAcounter == INTA_SECOND);
    assign w_aeoi_clr   = w_second_evt && bus.aeoi && !r_spurious;

    // The EOI search sees the ISR with the AEOI bit already removed, so a
    // coincident EOI retires the next level down rather than the same one.
    assign w_isr_eoi_view = r_isr & ~(w_aeoi_clr ? (8'(1) << r_ack_idx) : 8'h00);

    pic_priority_resolver u_isr_res (
        .i_req    (w_isr_eoi_view),
        .i_lowest (r_lowest),
        .o_valid  (w_isr_valid),
        .o_idx    (w_isr_idx)
    );

    // Fully nested: any in-service level of equal or higher rank blocks INT.
    always_comb begin
        w_blocked = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (r_isr[n] && (prio_rank(n[2:0], r_lowest) <= prio_rank(w_cand_idx, r_lowest)))
                w_blocked = 1'b1;
        end
    end

    assign bus.INTtocontrol = w_cand_valid && !w_blocked;
    assign bus.ISRtocontrol = r_ack_idx;

    always_comb begin
        if (bus.level_or_edge_flag)
            w_irr_next = w_in;
        else
            w_irr_next = w_in & (r_irr | ~r_in_prev);
        if (!bus.level_or_edge_flag && w_first_evt && w_cand_valid)
            w_irr_next[w_cand_idx] = 1'b0;

        w_isr_next = r_isr;
        if (w_first_evt && w_cand_valid)
            w_isr_next[w_cand_idx] = 1'b1;
        if (w_aeoi_clr)
            w_isr_next[r_ack_idx] = 1'b0;
        if (bus.eoi && w_isr_valid)
            w_isr_next[w_isr_idx] = 1'b0;

        w_lowest_next = r_lowest;
        if (w_aeoi_clr && bus.set)
            w_lowest_next = r_ack_idx;
        if (bus.eoi && w_isr_valid && bus.set)
            w_lowest_next = w_isr_idx;
        if (bus.reset)
            w_lowest_next = 3'd7;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irr       <= '0;
            r_isr       <= '0;
            r_in_prev   <= '0;
            r_inta_prev <= INTA_IDLE;
            r_lowest    <= 3'd7;
            r_ack_idx   <= '0;
            r_spurious  <= 1'b1;
        end else begin
            r_irr       <= w_irr_next;
            r_isr       <= w_isr_next;
            r_in_prev   <= w_in;
            r_inta_prev <= bus.intAcounter;
            r_lowest    <= w_lowest_next;
            if (w_first_evt) begin
                r_ack_idx  <= w_cand_valid ? w_cand_idx : SPURIOUS_IDX;
                r_spurious <= !w_cand_valid;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_block.sv
module tb_interrupt_block;
    import pic_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interrupt_block_if bus();

    interrupt_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ir(input logic [7:0] v);
        {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = v;
    endtask

    task automatic inta_first(input int exp_idx, input string tag);
        exp_q.push_back(exp_idx);
        bus.intAcounter = INTA_FIRST;
        tick();
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check_val(tag, 32'(bus.ISRtocontrol), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic inta_second();
        bus.intAcounter = INTA_SECOND;
        tick();
    endtask

    task automatic inta_idle();
        bus.intAcounter = INTA_IDLE;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_ir(8'h00);
        bus.level_or_edge_flag = 1'b1;
        bus.mask        = 8'h00;
        bus.set         = 1'b0;
        bus.reset       = 1'b0;
        bus.aeoi        = 1'b1;
        bus.eoi         = 1'b0;
        bus.intAcounter = INTA_IDLE;
        rst_n = 1'b0;
        tick();
        tick();
        check_val("rst_int", 32'(bus.INTtocontrol), 0);
        check_val("rst_isridx", 32'(bus.ISRtocontrol), 0);
        check_val("rst_lowest", 32'(dut.r_lowest), 7);
        check_val("rst_isr", 32'(dut.r_isr), 0);
        rst_n = 1'b1;
        tick();

        // level mode, fixed priority, AEOI
        set_ir(8'h02);
        tick();
        check_val("lvl_int_ir1", 32'(bus.INTtocontrol), 1);
        set_ir(8'h82);
        tick();
        inta_first(1, "lvl_ack_ir1");
        check_val("lvl_isr_set", 32'(dut.r_isr), 32'h02);
        check_val("lvl_int_blocked", 32'(bus.INTtocontrol), 0);
        set_ir(8'h80);
        inta_second();
        check_val("lvl_aeoi_clr", 32'(dut.r_isr), 0);
        check_val("lvl_int_ir7", 32'(bus.INTtocontrol), 1);
        inta_idle();
        inta_first(7, "lvl_ack_ir7");
        tick();
        check_val("lvl_hold_one_evt", 32'(dut.r_isr), 32'h80);
        inta_second();
        check_val("lvl_aeoi_clr7", 32'(dut.r_isr), 0);
        set_ir(8'h00);
        inta_idle();
        check_val("lvl_int_idle", 32'(bus.INTtocontrol), 0);

        // rotation
        bus.set = 1'b1;
        set_ir(8'h02);
        tick();
        inta_first(1, "rot_ack_ir1");
        inta_second();
        check_val("rot_lowest1", 32'(dut.r_lowest), 1);
        check_val("rot_isr_clr", 32'(dut.r_isr), 0);
        inta_idle();
        set_ir(8'h82);
        tick();
        inta_first(7, "rot_ir7_wins");
        inta_second();
        check_val("rot_lowest7", 32'(dut.r_lowest), 7);
        inta_idle();
        inta_first(1, "rot_then_ir1");
        bus.reset = 1'b1;
        inta_second();
        check_val("rot_reset_prec", 32'(dut.r_lowest), 7);
        bus.reset = 1'b0;
        bus.set   = 1'b0;
        set_ir(8'h00);
        inta_idle();

        // masking and nesting, explicit EOI
        bus.aeoi = 1'b0;
        bus.mask = 8'h02;
        set_ir(8'h0A);
        tick();
        inta_first(3, "mask_ack_ir3");
        check_val("mask_isr3", 32'(dut.r_isr), 32'h08);
        inta_second();
        check_val("mask_no_aeoi", 32'(dut.r_isr), 32'h08);
        inta_idle();
        check_val("nest_int_self", 32'(bus.INTtocontrol), 0);
        set_ir(8'h0E);
        tick();
        check_val("nest_int_ir2", 32'(bus.INTtocontrol), 1);
        set_ir(8'h20);
        tick();
        check_val("nest_int_ir5", 32'(bus.INTtocontrol), 0);
        check_val("mask_irr_kept", 32'(dut.r_irr), 32'h20);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check_val("eoi_clr3", 32'(dut.r_isr), 0);
        check_val("eoi_int_ir5", 32'(bus.INTtocontrol), 1);
        set_ir(8'h00);
        bus.mask = 8'h00;
        tick();

        // simultaneous AEOI and EOI
        set_ir(8'h08);
        tick();
        inta_first(3, "dual_ack_ir3");
        inta_second();
        inta_idle();
        set_ir(8'h0A);
        tick();
        check_val("dual_int_ir1", 32'(bus.INTtocontrol), 1);
        inta_first(1, "dual_ack_ir1");
        check_val("dual_isr_two", 32'(dut.r_isr), 32'h0A);
        bus.aeoi = 1'b1;
        bus.eoi  = 1'b1;
        inta_second();
        bus.eoi = 1'b0;
        check_val("dual_isr_empty", 32'(dut.r_isr), 0);
        set_ir(8'h00);
        inta_idle();

        // edge mode
        bus.level_or_edge_flag = 1'b0;
        set_ir(8'h10);
        tick();
        check_val("edge_int", 32'(bus.INTtocontrol), 1);
        inta_first(4, "edge_ack_ir4");
        check_val("edge_irr_clr", 32'(bus.INTtocontrol), 0);
        inta_second();
        inta_idle();
        tick();
        tick();
        check_val("edge_held_no_int", 32'(bus.INTtocontrol), 0);
        set_ir(8'h00);
        tick();
        set_ir(8'h10);
        tick();
        check_val("edge_rerequest", 32'(bus.INTtocontrol), 1);
        inta_first(4, "edge_ack_again");
        inta_second();
        inta_idle();
        set_ir(8'h00);
        tick();
        bus.level_or_edge_flag = 1'b1;

        // spurious
        set_ir(8'h01);
        tick();
        set_ir(8'h00);
        tick();
        inta_first(7, "spurious_idx");
        check_val("spurious_isr", 32'(dut.r_isr), 0);
        inta_second();
        inta_idle();

        // block reset mid-sequence
        bus.set = 1'b1;
        set_ir(8'h04);
        tick();
        inta_first(2, "rst_pre_ack");
        inta_second();
        check_val("rst_pre_lowest", 32'(dut.r_lowest), 2);
        inta_idle();
        bus.intAcounter = INTA_FIRST;
        rst_n = 1'b0;
        tick();
        check_val("midrst_isridx", 32'(bus.ISRtocontrol), 0);
        check_val("midrst_int", 32'(bus.INTtocontrol), 0);
        check_val("midrst_lowest", 32'(dut.r_lowest), 7);
        check_val("midrst_isr", 32'(dut.r_isr), 0);
        rst_n = 1'b1;
        set_ir(8'h00);
        inta_second();
        check_val("midrst_second_isr", 32'(dut.r_isr), 0);
        check_val("midrst_second_idx", 32'(bus.ISRtocontrol), 0);
        inta_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_block.md
# interrupt_block

Interrupt request/service core of the 8259-compatible PIC. It captures the eight IR inputs into the IRR and applies the mask, resolving priority with optional automatic rotation. It raises INT toward the control logic, and on the INTA sequence moves the winning level into the ISR and reports its 3-bit index. EOI handling covers both automatic (AEOI) and non-specific explicit EOI.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i0..i7  in  1 each  interrupt request lines IR0..IR7.
- level_or_edge_flag  in  1  1 = level-triggered, 0 = rising-edge-triggered.
- mask  in  8  IMR; bit n = 1 blocks IRn from priority resolution; the IRR bit is not cleared.
- set  in  1  1 = rotation mode (rotate on AEOI/EOI).
- reset  in  1  priority reset; sampled 1 returns priority to fixed order (IR0 highest). This is not the block reset.
- aeoi  in  1  1 = automatic EOI at second INTA.
- eoi  in  1  non-specific EOI command strobe; acts on each cycle sampled high.
- intAcounter  in  2  INTA phase from control: 00 idle, 01 first pulse, 10 second pulse, 11 treated as idle.
- INTtocontrol  out  1  interrupt request to control logic.
- ISRtocontrol  out  3  index of the level acknowledged by the latest first INTA.

## Operation
- IRR, level mode: irr[n] <= in[n] every cycle.
- IRR, edge mode: irr[n] set when in[n] is sampled 1 and was 0 on the previous cycle. Cleared when in[n] is sampled 0 or when level n is acknowledged.
- Priority pointer `lowest` (3 bits, reset 7). Priority order is lowest+1 (highest) … lowest (lowest), modulo 8.
- Candidate: highest-priority bit of irr & ~mask.
- INTtocontrol = candidate exists AND its priority is strictly higher than every set ISR bit (fully nested). Combinational from registered IRR/ISR/mask.
- INTA events are detected on intAcounter changes, using a registered previous value:
  - First pulse: value becomes 01. If a candidate exists, set isr[c], clear irr[c] (edge mode), ISRtocontrol <= c. If none exists, ISRtocontrol <= 7 (spurious) and the ISR is unchanged.
  - Second pulse: value becomes 10. If aeoi=1 and the first pulse was not spurious, clear isr[c]. If set=1, also lowest <= c.
- eoi=1: clear the highest-priority set ISR bit. If set=1, lowest <= that index. No effect if the ISR is empty.
- reset=1: lowest <= 7. This takes precedence over any rotation in the same cycle.
- Simultaneous second-pulse AEOI and eoi in one cycle: AEOI is applied to c; eoi then clears the next-highest remaining ISR bit.

## Timing
- Input to IRR: 1 cycle. IRR to INTtocontrol: same cycle (0 added latency).
- INTA event to ISR/ISRtocontrol/pointer update: 1 cycle after the intAcounter change is sampled.
- Holding intAcounter at 01 or 10 for several cycles produces exactly one event.
- rst_n=0 on a clock edge: irr, isr, previous-INTA, and previous-input registers go to 0; lowest=7; ISRtocontrol=0; INTtocontrol=0. This applies mid-sequence as well, and the INTA sequence is abandoned.

## Structure
- Shared package pic_pkg: INTA_IDLE=2'b00, INTA_FIRST=2'b01, INTA_SECOND=2'b10, SPURIOUS_IDX=3'd7, and a function or typedef for the 3-bit level index.
- One sub-module, pic_priority_resolver: combinational; takes an 8-bit request vector and the lowest pointer, returns valid plus a 3-bit index. It is instantiated twice, once for IRR & ~mask and once for the ISR.

## Test plan
- Level mode, fixed priority, aeoi=1: i1=1 then i7=1, INTA 01→10 → INTtocontrol=1, ISRtocontrol=1, isr=0 after second pulse, INT remains 1 for IR7.
- Spurious: i0 pulses high for one cycle and drops before intAcounter=01 → ISRtocontrol=7, isr=00000000.
- Rotation: set=1, i1 acknowledged with AEOI → lowest=1. Then i1=i7=1 → IR7 wins (ISRtocontrol=7), then IR1.
- Masking/nesting: mask=8'b0000_0010, i1=i3=1 → ISRtocontrol=3. With isr[3] set (aeoi=0), a new i2 asserts INT and i5 does not; eoi=1 clears isr[3].
- Edge mode: level_or_edge_flag=0, i4 held high → one INT/acknowledge only; it re-requests only after i4 falls and rises.
- rst_n=0 during intAcounter=01 → all outputs 0, lowest=7, no ISR bit set on the following 10.
